tx_arbiter: RTL

//  Round-robin arbiter and byte sequencer that shares the single serial writer (UART TX serializer) among N word sources.

---
 rtl/tx_arbiter_pkg.sv | 20 ++
 rtl/tx_arbiter_rr_pick.sv | 27 ++
 rtl/tx_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the serial-writer arbiter: FSM encoding,
// frame byte counts and the header byte layout.
package tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] HDR_NIBBLE      = 4'hA;
  localparam logic [1:0] FRAME_BYTES_HDR = 2'd3;
  localparam logic [1:0] FRAME_BYTES_RAW = 2'd2;

  // Header identifies the source and its tag so the receiver can demultiplex.
  function automatic logic [7:0] hdr_byte(input logic [1:0] src, input logic [1:0] tag);
    return {HDR_NIBBLE, src, tag};
  endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning
// rr_ptr+1, rr_ptr+2, ... modulo N.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   rr_ptr,
  output logic         gnt_valid,
  output logic [1:0]   gnt_idx
);

  logic [N-1:0] shifted;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    shifted   = '0;
    for (int k = 1; k <= N; k++) begin
      shifted = req >> ((int'(rr_ptr) + k) % N);
      if (!gnt_valid && shifted[0]) begin
        gnt_valid = 1'b1;
        gnt_idx   = 2'((int'(rr_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one serial writer among N word sources,
// sending each granted word as [header], high byte, low byte.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int N      = 2,
  parameter bit HDR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*16-1:0] data,
  input  logic [N*2-1:0]  addr,
  output logic [N-1:0]    ack,
  output logic            busy,
  input  logic            tbr,
  output logic            write,
  output logic [7:0]      data_out,
  output logic [15:0]     frames
);

  state_t       state_q, state_d;
  logic [1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]   src_q, src_d;
  logic [1:0]   tag_q, tag_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [15:0]  word_q, word_d;
  logic [15:0]  frames_q, frames_d;
  logic [N-1:0] ack_q, ack_d;
  logic         busy_q, busy_d;
  logic         write_q, write_d;
  logic [7:0]   data_out_q, data_out_d;
  logic [7:0]   cur_byte;
  logic         gnt_valid;
  logic [1:0]   gnt_idx;

  rr_pick #(.N(N)) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Remaining-byte count selects the byte, so header/raw modes share one path.
  always_comb begin
    case (cnt_q)
      2'd3:    cur_byte = hdr_byte(src_q, tag_q);
      2'd2:    cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    src_d      = src_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    frames_d   = frames_q;
    ack_d      = '0;
    busy_d     = busy_q;
    write_d    = 1'b0;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          src_d    = gnt_idx;
          rr_ptr_d = gnt_idx;
          word_d   = 16'(data >> {gnt_idx, 4'b0000});
          tag_d    = 2'(addr >> {gnt_idx, 1'b0});
          cnt_d    = HDR_EN ? FRAME_BYTES_HDR : FRAME_BYTES_RAW;
          ack_d    = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
          busy_d   = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tbr) begin
          write_d    = 1'b1;
          data_out_d = cur_byte;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          frames_d = frames_q + 16'd1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'(N - 1);
      src_q      <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      frames_q   <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      write_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      src_q      <= src_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      frames_q   <= frames_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      write_q    <= write_d;
      data_out_q <= data_out_d;
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign write    = write_q;
  assign data_out = data_out_q;
  assign frames   = frames_q;

endmodule
